// File: rtl/mem_cmd_responder.sv
// mem_cmd_responder: memory-side responder for the 8x8 memory IC command FSM.
// Accepts one read or write per select assertion, performs it on a small
// register array, returns an ack (plus rvalid/rdata for reads) and then waits
// for select to be released before accepting another command.
//
// Optional feature: define MEM_CLEAR_ON_RESET_EN to clear every array word on
// the synchronous reset edge. Without it the array has no reset and keeps its
// contents across i_reset.
//
// Handshake: a command is accepted on the rising edge where the FSM is in IDLE
// and i_select=1; o_ack (and o_rvalid for reads) pulses for exactly one cycle
// two edges later, and no new command is accepted until i_select has been seen
// low in RELEASE.
module mem_cmd_responder #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_operation,
    input  logic              i_select,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_ack,
    output logic              o_busy,
    output logic [1:0]        o_dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_DONE    = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

    state_t              state_q;
    logic                op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;
    logic                ack_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;

    // The array is written only during ACCESS of a captured write command.
    assign mem_we = (state_q == ST_ACCESS) && op_q;

    // Command FSM: capture on accept, access, acknowledge, wait for release.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_select) begin
                        op_q    <= i_operation;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!op_q) begin
                        rdata_q <= mem_q[addr_q];
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    ack_q    <= 1'b1;
                    rvalid_q <= !op_q;
                    state_q  <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // A held select must not launch a second command.
                    if (!i_select) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    // Storage array: cleared on reset, reset also wins over a pending write.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end
`else
    // Storage array: no reset, but a reset edge still suppresses a pending write.
    always_ff @(posedge i_clock) begin
        if (mem_we && !i_reset) begin
            mem_q[addr_q] <= wdata_q;
        end
    end
`endif

    assign o_rdata     = rdata_q;
    assign o_rvalid    = rvalid_q;
    assign o_ack       = ack_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Bench for mem_cmd_responder: constant vector table, hand-written reset
// corner cases, then random commands against a word-array reference model.
module tb_mem_cmd_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       ack;
  logic       busy;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;

  // reference model: array contents and last completed read value
  logic [7:0] mem_ref [8];
  logic [7:0] rd_ref = 8'h00;

  mem_cmd_responder #(.ADDR_W(3), .DATA_W(8)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_operation(op),
    .i_select(sel),
    .i_addr(addr),
    .i_wdata(wdata),
    .o_rdata(rdata),
    .o_rvalid(rvalid),
    .o_ack(ack),
    .o_busy(busy),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rd_ref = 8'h00;
`ifdef MEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 8; i++) mem_ref[i] = 8'h00;
`endif
  endtask

  // hold reset for n cycles with select low; outputs must stay idle
  task automatic reset_pulse(input int n);
    rst = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 8'h00);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // one full command: accept, ack two edges later, hold select, release
  task automatic do_cmd(input logic c_op, input logic [2:0] c_addr, input logic [7:0] c_data,
                        input int hold);
    logic [7:0] exp_rd;
    op = c_op;
    addr = c_addr;
    wdata = c_data;
    sel = 1'b1;
    if (c_op) mem_ref[c_addr] = c_data;
    else rd_ref = mem_ref[c_addr];
    exp_rd = rd_ref;
    @(negedge clk);
    chk("acc_busy", busy, 1);
    chk("acc_ack", ack, 0);
    // inputs after accept must be ignored
    op = ~c_op;
    addr = 3'($urandom);
    wdata = 8'($urandom);
    @(negedge clk);
    chk("done_ack", ack, 0);
    @(negedge clk);
    chk("ack_pulse", ack, 1);
    chk("ack_rvalid", rvalid, {31'd0, ~c_op});
    chk("ack_rdata", rdata, exp_rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ack", ack, 0);
      chk("hold_rvalid", rvalid, 0);
      chk("hold_busy", busy, 1);
      chk("hold_rdata", rdata, exp_rd);
    end
    sel = 1'b0;
    @(negedge clk);
    chk("rel_busy", busy, 0);
    chk("rel_ack", ack, 0);
    chk("rel_rdata", rdata, exp_rd);
  endtask

  typedef struct {
    logic       op;
    logic [2:0] addr;
    logic [7:0] wdata;
    int         hold;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // reset then idle
    reset_pulse(2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_ack", ack, 0);
      chk("idle_rdata", rdata, 8'h00);
    end

    // vector table: write/read, held select, fill and sweep
    vecs.push_back('{1'b1, 3'd3, 8'hA5, 0, 8'h00});
    vecs.push_back('{1'b0, 3'd3, 8'h00, 2, 8'hA5});
    vecs.push_back('{1'b1, 3'd5, 8'h3C, 8, 8'h00});
    vecs.push_back('{1'b0, 3'd5, 8'h00, 0, 8'h3C});
    for (int k = 0; k < 8; k++) vecs.push_back('{1'b1, 3'(k), 8'(8'h10 + k), 0, 8'h00});
    for (int k = 0; k < 8; k++) vecs.push_back('{1'b0, 3'(k), 8'h00, 0, 8'(8'h10 + k)});
    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold);
      if (!vecs[i].op) chk("vec_rdata", rdata, vecs[i].exp_rdata);
    end

    // reset on the ACCESS edge of a write: no ack, write suppressed
    do_cmd(1'b1, 3'd2, 8'h55, 0);
    op = 1'b1; addr = 3'd2; wdata = 8'hFF; sel = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ack", ack, 0);
    chk("mid_busy_rst", busy, 0);
    rst = 1'b0;
    sel = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_ack_after", ack, 0);
    do_cmd(1'b0, 3'd2, 8'h00, 0);
`ifdef MEM_CLEAR_ON_RESET_EN
    chk("mid_read", rdata, 8'h00);
`else
    chk("mid_read", rdata, 8'h55);
`endif

    // reset while in DONE: ack pulse must not appear
    op = 1'b1; addr = 3'd6; wdata = 8'h77; sel = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ref[6] = 8'h77;
    rst = 1'b1;
    @(negedge clk);
    chk("done_rst_ack", ack, 0);
    chk("done_rst_rvalid", rvalid, 0);
    rst = 1'b0;
    sel = 1'b0;
    model_reset();
    @(negedge clk);
    chk("done_rst_ack2", ack, 0);
    do_cmd(1'b0, 3'd6, 8'h00, 0);

    // reset retention
    do_cmd(1'b1, 3'd7, 8'h99, 0);
    reset_pulse(1);
    do_cmd(1'b0, 3'd7, 8'h00, 0);
`ifdef MEM_CLEAR_ON_RESET_EN
    chk("ret_read", rdata, 8'h00);
`else
    chk("ret_read", rdata, 8'h99);
`endif

    // random commands against the model (every word has been written by now)
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 11) == 0) reset_pulse($urandom_range(1, 2));
      do_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
